// File: rtl/moving_obstacle_pkg.sv
// obstacle_pkg: shared FSM encoding, playfield size, axis codes and a coordinate clamp helper.
// Rev 1.0
`default_nettype none
package obstacle_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } obs_state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int AXIS_V   = 0;
  localparam int AXIS_H   = 1;

  function automatic logic [7:0] clamp_pos(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage
`default_nettype wire

// File: rtl/moving_obstacle_if.sv
// moving_obstacle_if: control, head-position and draw-port bundle of the moving obstacle.
// Rev 1.0
`default_nettype none
interface moving_obstacle_if #(parameter int NHEADS = 2);
  logic                  enable;
  logic                  move;
  logic [7:0]            fixed_coord;
  logic [7:0]            start_pos;
  logic                  clear_hit;
  logic [3:0]            seg_idx;
  logic [NHEADS*8-1:0]   heads_x;
  logic [NHEADS*8-1:0]   heads_y;
  logic [7:0]            out_x;
  logic [6:0]            out_y;
  logic                  out_valid;
  logic                  dir;
  logic                  endgame;

  modport master (
    output enable, move, fixed_coord, start_pos, clear_hit, seg_idx, heads_x, heads_y,
    input  out_x, out_y, out_valid, dir, endgame
  );

  modport slave (
    input  enable, move, fixed_coord, start_pos, clear_hit, seg_idx, heads_x, heads_y,
    output out_x, out_y, out_valid, dir, endgame
  );
endinterface
`default_nettype wire

// File: rtl/moving_obstacle_hit_check.sv
// obstacle_hit_check: combinational test of one snake head against the bar's cell span.
// Rev 1.0
`default_nettype none
module obstacle_hit_check
  import obstacle_pkg::*;
#(
  parameter int LEN  = 10,
  parameter int AXIS = 0
) (
  input  wire logic [7:0] i_fixed_coord,
  input  wire logic [7:0] i_pos,
  input  wire logic [7:0] i_head_x,
  input  wire logic [7:0] i_head_y,
  output logic            o_hit
);
  logic [7:0] w_fix;
  logic [7:0] w_trav;
  logic [8:0] w_last;

  always_comb begin
    w_fix  = i_head_x;
    w_trav = i_head_y;
    if (AXIS == AXIS_H) begin
      w_fix  = i_head_y;
      w_trav = i_head_x;
    end
  end

  // Nine bits so the span end never wraps near the top of the coordinate range
  assign w_last = {1'b0, i_pos} + 9'(LEN - 1);
  assign o_hit  = (w_fix == i_fixed_coord) && (w_trav >= i_pos) && ({1'b0, w_trav} <= w_last);
endmodule
`default_nettype wire

// File: rtl/moving_obstacle.sv
// moving_obstacle: bouncing bar obstacle with move divider, multi-head collision and draw port.
// Rev 1.0 -- OBSTACLE_SPEEDUP_EN: divider shrinks by one on each reversal (floor 1).
`default_nettype none
module moving_obstacle
  import obstacle_pkg::*;
#(
  parameter int LEN      = 10,
  parameter int AXIS     = 0,
  parameter int MIN_POS  = 0,
  parameter int MAX_POS  = 119,
  parameter int MOVE_DIV = 1,
  parameter int NHEADS   = 2
) (
  input wire logic         clock,
  input wire logic         resetn,
  moving_obstacle_if.slave bus
);
  localparam logic [7:0] c_MIN   = 8'(MIN_POS);
  localparam logic [7:0] c_TOP   = 8'(MAX_POS - LEN + 1);
  localparam bit         c_FIXED = (LEN == MAX_POS - MIN_POS + 1);

  obs_state_t r_state, w_state_nxt;
  logic [7:0] r_pos, w_pos_nxt;
  logic       r_dir, w_dir_nxt;
  logic [3:0] r_div_cnt, w_div_nxt;
  logic       r_endgame, w_endgame_nxt;
  logic [3:0] w_div;
  logic       w_rev;
  logic [NHEADS-1:0] w_hits;
  logic [7:0] w_cell;

`ifdef OBSTACLE_SPEEDUP_EN
  logic [3:0] r_cur_div, w_cur_div_nxt;
  assign w_div = r_cur_div;
`else
  assign w_div = 4'(MOVE_DIV);
`endif

  for (genvar k = 0; k < NHEADS; k++) begin : g_heads
    obstacle_hit_check #(.LEN(LEN), .AXIS(AXIS)) u_hit (
      .i_fixed_coord (bus.fixed_coord),
      .i_pos         (r_pos),
      .i_head_x      (bus.heads_x[8*k +: 8]),
      .i_head_y      (bus.heads_y[8*k +: 8]),
      .o_hit         (w_hits[k])
    );
  end

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_dir_nxt     = r_dir;
    w_div_nxt     = r_div_cnt;
    w_endgame_nxt = r_endgame;
    w_rev         = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.enable) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!bus.enable) begin
          w_state_nxt = ST_IDLE;
        end else if (|w_hits) begin
          w_state_nxt   = ST_HIT;
          w_endgame_nxt = 1'b1;
        end else if (bus.move) begin
          if (r_div_cnt >= w_div - 4'd1) begin
            w_div_nxt = 4'd0;
            if (!c_FIXED) begin
              // c_TOP is where the far cell sits on MAX_POS
              if (r_dir) begin
                if (r_pos == c_TOP) begin
                  w_dir_nxt = 1'b0;
                  w_pos_nxt = r_pos - 8'd1;
                  w_rev     = 1'b1;
                end else begin
                  w_pos_nxt = r_pos + 8'd1;
                end
              end else begin
                if (r_pos == c_MIN) begin
                  w_dir_nxt = 1'b1;
                  w_pos_nxt = r_pos + 8'd1;
                  w_rev     = 1'b1;
                end else begin
                  w_pos_nxt = r_pos - 8'd1;
                end
              end
            end
          end else begin
            w_div_nxt = r_div_cnt + 4'd1;
          end
        end
      end
      ST_HIT: begin
        if (bus.clear_hit) begin
          w_state_nxt   = ST_IDLE;
          w_endgame_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef OBSTACLE_SPEEDUP_EN
  always_comb begin
    w_cur_div_nxt = r_cur_div;
    if (w_rev) w_cur_div_nxt = (r_cur_div > 4'd1) ? r_cur_div - 4'd1 : 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) r_cur_div <= 4'(MOVE_DIV);
    else         r_cur_div <= w_cur_div_nxt;
  end
`else
  logic w_rev_unused;
  assign w_rev_unused = w_rev;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pos     <= clamp_pos(bus.start_pos, c_MIN, c_TOP);
      r_dir     <= 1'b1;
      r_div_cnt <= 4'd0;
      r_endgame <= 1'b0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_div_cnt <= w_div_nxt;
      r_endgame <= w_endgame_nxt;
    end
  end

  assign w_cell        = r_pos + {4'd0, bus.seg_idx};
  assign bus.out_valid = (bus.seg_idx < 4'(LEN));
  assign bus.out_x     = !bus.out_valid ? 8'd0 : (AXIS == AXIS_H) ? w_cell : bus.fixed_coord;
  assign bus.out_y     = !bus.out_valid ? 7'd0 :
                         (AXIS == AXIS_H) ? bus.fixed_coord[6:0] : w_cell[6:0];
  assign bus.dir       = r_dir;
  assign bus.endgame   = r_endgame;
endmodule
`default_nettype wire

// File: tb/tb_moving_obstacle.sv
// tb_moving_obstacle: directed scoreboard bench covering several parameterisations of moving_obstacle.
// Rev 1.0
`default_nettype none
module tb_moving_obstacle;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  moving_obstacle_if #(.NHEADS(2)) if0 ();
  moving_obstacle_if #(.NHEADS(2)) if1 ();
  moving_obstacle_if #(.NHEADS(2)) if2 ();
  moving_obstacle_if #(.NHEADS(2)) if3 ();
  moving_obstacle_if #(.NHEADS(2)) if4 ();

  moving_obstacle #(.LEN(10), .AXIS(0), .MIN_POS(0), .MAX_POS(119), .MOVE_DIV(1), .NHEADS(2))
    dut0 (.clock(clock), .resetn(resetn), .bus(if0.slave));
  moving_obstacle #(.LEN(10), .AXIS(0), .MIN_POS(0), .MAX_POS(119), .MOVE_DIV(3), .NHEADS(2))
    dut1 (.clock(clock), .resetn(resetn), .bus(if1.slave));
  moving_obstacle #(.LEN(10), .AXIS(1), .MIN_POS(0), .MAX_POS(159), .MOVE_DIV(1), .NHEADS(2))
    dut2 (.clock(clock), .resetn(resetn), .bus(if2.slave));
  moving_obstacle #(.LEN(4), .AXIS(0), .MIN_POS(10), .MAX_POS(13), .MOVE_DIV(1), .NHEADS(2))
    dut3 (.clock(clock), .resetn(resetn), .bus(if3.slave));
  moving_obstacle #(.LEN(10), .AXIS(0), .MIN_POS(0), .MAX_POS(11), .MOVE_DIV(4), .NHEADS(2))
    dut4 (.clock(clock), .resetn(resetn), .bus(if4.slave));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic cmp(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        errors++;
        $display("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
        $error("check %s", it.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_move(input int which, input logic v);
    case (which)
      0: if0.move = v;
      1: if1.move = v;
      2: if2.move = v;
      3: if3.move = v;
      default: if4.move = v;
    endcase
  endtask

  // n consecutive single-cycle game ticks on one instance
  task automatic mv(input int which, input int n);
    set_move(which, 1'b1);
    repeat (n) tick();
    set_move(which, 1'b0);
  endtask

  task automatic init_if0();
    if0.enable = 0; if0.move = 0; if0.clear_hit = 0; if0.seg_idx = 0;
    if0.fixed_coord = 8'd40; if0.start_pos = 8'd5; if0.heads_x = '0; if0.heads_y = '0;
  endtask

  initial begin
    init_if0();
    if1.enable = 0; if1.move = 0; if1.clear_hit = 0; if1.seg_idx = 0;
    if1.fixed_coord = 8'd40; if1.start_pos = 8'd5; if1.heads_x = '0; if1.heads_y = '0;
    if2.enable = 0; if2.move = 0; if2.clear_hit = 0; if2.seg_idx = 0;
    if2.fixed_coord = 8'd60; if2.start_pos = 8'd40;
    if2.heads_x = {8'd0, 8'd45}; if2.heads_y = {8'd0, 8'd60};
    if3.enable = 0; if3.move = 0; if3.clear_hit = 0; if3.seg_idx = 0;
    if3.fixed_coord = 8'd40; if3.start_pos = 8'd0; if3.heads_x = '0; if3.heads_y = '0;
    if4.enable = 0; if4.move = 0; if4.clear_hit = 0; if4.seg_idx = 0;
    if4.fixed_coord = 8'd40; if4.start_pos = 8'd0; if4.heads_x = '0; if4.heads_y = '0;

    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    push("rst_pos", 5); push("rst_dir", 1); push("rst_endgame", 0); push("rst_state", 0);
    push("rst_out_x", 40); push("rst_clamp_low", 10);
    cmp(32'(if0.out_y)); cmp(32'(if0.dir)); cmp(32'(if0.endgame)); cmp(32'(dut0.r_state));
    cmp(32'(if0.out_x)); cmp(32'(if3.out_y));

    if0.enable = 1; if3.enable = 1;
    tick();
    push("idle_to_run", 1); cmp(32'(dut0.r_state));
    mv(0, 3);
    push("three_moves_pos", 8); push("three_moves_dir", 1);
    cmp(32'(if0.out_y)); cmp(32'(if0.dir));
    mv(3, 3);
    push("full_span_static", 10); push("full_span_dir", 1);
    cmp(32'(if3.out_y)); cmp(32'(if3.dir));

    if0.seg_idx = 4'd9; #1;
    push("seg9_y", 17); push("seg9_valid", 1);
    cmp(32'(if0.out_y)); cmp(32'(if0.out_valid));
    if0.seg_idx = 4'd10; #1;
    push("seg10_valid", 0); push("seg10_y", 0); push("seg10_x", 0);
    cmp(32'(if0.out_valid)); cmp(32'(if0.out_y)); cmp(32'(if0.out_x));
    if0.seg_idx = 4'd0; #1;

    mv(0, 12);
    push("pos_20", 20); cmp(32'(if0.out_y));
    if0.heads_x = {8'd40, 8'd0}; if0.heads_y = {8'd30, 8'd0};
    tick(); tick();
    push("head_past_end_endgame", 0); push("head_past_end_state", 1);
    cmp(32'(if0.endgame)); cmp(32'(dut0.r_state));
    if0.heads_x = {8'd41, 8'd0}; if0.heads_y = {8'd25, 8'd0};
    tick();
    push("head_wrong_column", 0); cmp(32'(if0.endgame));
    if0.heads_x = {8'd40, 8'd0}; if0.heads_y = {8'd29, 8'd0};
    tick();
    push("hit_endgame", 1); push("hit_state", 2);
    cmp(32'(if0.endgame)); cmp(32'(dut0.r_state));
    mv(0, 3);
    push("hit_frozen_pos", 20); push("hit_sticky", 1);
    cmp(32'(if0.out_y)); cmp(32'(if0.endgame));
    if0.heads_x = '0; if0.heads_y = '0;
    if0.clear_hit = 1;
    tick();
    if0.clear_hit = 0;
    push("clear_endgame", 0); push("clear_state", 0);
    cmp(32'(if0.endgame)); cmp(32'(dut0.r_state));

    // Bounce at the top edge after a clamped reset, then walk down to the bottom edge
    resetn = 1'b0; if0.start_pos = 8'd200;
    tick();
    resetn = 1'b1;
    push("clamp_high", 110); push("clamp_dir", 1);
    cmp(32'(if0.out_y)); cmp(32'(if0.dir));
    tick();
    mv(0, 1);
    push("top_rev_dir", 0); push("top_rev_pos", 109);
    cmp(32'(if0.dir)); cmp(32'(if0.out_y));
    mv(0, 109);
    push("bottom_pos", 0); push("bottom_dir", 0);
    cmp(32'(if0.out_y)); cmp(32'(if0.dir));
    mv(0, 1);
    push("bottom_rev_dir", 1); push("bottom_rev_pos", 1);
    cmp(32'(if0.dir)); cmp(32'(if0.out_y));

    // Divider of 3 with an enable gap
    if1.enable = 1;
    tick();
    mv(1, 4);
    push("div3_four_pulses", 6); cmp(32'(if1.out_y));
    if1.enable = 0;
    tick();
    mv(1, 2);
    push("div3_hold_pos", 6); push("div3_hold_cnt", 1);
    cmp(32'(if1.out_y)); cmp(32'(dut1.r_div_cnt));
    if1.enable = 1;
    tick();
    mv(1, 2);
    push("div3_six_pulses", 7); push("div3_cnt_wrap", 0);
    cmp(32'(if1.out_y)); cmp(32'(dut1.r_div_cnt));

    // Horizontal bar, head 0 on it
    if2.enable = 1;
    tick(); tick();
    push("h_hit_endgame", 1); push("h_hit_state", 2); push("h_out_x", 40); push("h_out_y", 60);
    cmp(32'(if2.endgame)); cmp(32'(dut2.r_state)); cmp(32'(if2.out_x)); cmp(32'(if2.out_y));
    if2.seg_idx = 4'd12; #1;
    push("h_seg12_valid", 0); cmp(32'(if2.out_valid));
    if2.seg_idx = 4'd0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    push("reset_over_hit_endgame", 0); push("reset_over_hit_state", 0);
    cmp(32'(if2.endgame)); cmp(32'(dut2.r_state));

`ifdef OBSTACLE_SPEEDUP_EN
    if4.enable = 1;
    tick();
    mv(4, 22);
    push("spd_three_rev_pos", 1); push("spd_three_rev_div", 1); push("spd_three_rev_dir", 0);
    cmp(32'(if4.out_y)); cmp(32'(dut4.r_cur_div)); cmp(32'(if4.dir));
    mv(4, 1);
    push("spd_single_pulse", 0); cmp(32'(if4.out_y));
    mv(4, 1);
    push("spd_fourth_rev_pos", 1); push("spd_floor", 1);
    cmp(32'(if4.out_y)); cmp(32'(dut4.r_cur_div));
    mv(4, 1);
    push("spd_after_floor", 2); cmp(32'(if4.out_y));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
